// File: rtl/seq_divider4b.sv
// seq_divider4b: multi-cycle unsigned restoring divider.
// Each RUN cycle does one shift plus one trial subtraction, using a
// ripple full-adder chain (divisor inverted, carry-in 1).
// Optional macro DIV_ZERO_CHK_EN: a zero divisor skips RUN, goes straight
// to DONE and raises div_zero.
// Without it, divide-by-zero runs all iterations and gives quotient=all ones,
// remainder=dividend, and div_zero stays 0.
module seq_divider4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;

  // The remainder accumulator is kept WIDTH bits wide. After every step it
  // is strictly below the divisor, so its extra top bit would always be 0.
  // That bit only exists in the shifted value feeding the trial subtraction.
  logic [WIDTH-1:0] r_rem_acc;
  logic [WIDTH-1:0] r_quo_acc;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_fast;
  logic             w_last;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_sub_b;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_new;
  logic [WIDTH-1:0] w_quo_new;

  // start is honoured only while idle or in the done cycle.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_CHK_EN
  assign w_fast = w_accept && (divisor == '0);
`else
  assign w_fast = 1'b0;
`endif

  // Shift {rem,quo} left by one; the quotient MSB moves into the remainder.
  assign w_rem_sh = {1'b0, r_rem_acc[WIDTH-1:0], r_quo_acc[WIDTH-1]};
  assign w_sub_b  = ~{1'b0, r_divisor};

  // Trial subtraction w_rem_sh - divisor, as a ripple of full adders.
  assign w_carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
      assign w_trial[gi] = w_rem_sh[gi] ^ w_sub_b[gi] ^ w_carry[gi];
      if (gi < WIDTH) begin : g_carry
        assign w_carry[gi+1] = (w_rem_sh[gi] & w_sub_b[gi]) |
                               (w_rem_sh[gi] & w_carry[gi]) |
                               (w_sub_b[gi]  & w_carry[gi]);
      end
    end
  endgenerate

  // A clear sign bit means the divisor fit: keep the difference, quotient bit 1.
  assign w_fits    = ~w_trial[WIDTH];
  assign w_rem_new = w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_new = {r_quo_acc[WIDTH-2:0], w_fits};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_fast ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_state_next = w_fast ? S_DONE : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Working accumulators: load on accept, iterate while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem_acc <= '0;
      r_quo_acc <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_rem_acc <= '0;
      r_quo_acc <= dividend;
      r_divisor <= divisor;
      r_cnt     <= '0;
    end else if (r_state == S_RUN) begin
      r_rem_acc <= w_rem_new;
      r_quo_acc <= w_quo_new;
      r_cnt     <= r_cnt + CW'(1);
    end
  end

  // Result registers change only when entering DONE and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_fast) begin
      r_quotient  <= '1;
      r_remainder <= dividend;
    end else if ((r_state == S_RUN) && w_last) begin
      r_quotient  <= w_quo_new;
      r_remainder <= w_rem_new;
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;

`ifdef DIV_ZERO_CHK_EN
  logic r_div_zero;

  // Zero-divisor flag: set by the fast path, cleared by any other accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_zero <= 1'b0;
    end else if (w_fast) begin
      r_div_zero <= 1'b1;
    end else if (w_accept) begin
      r_div_zero <= 1'b0;
    end
  end

  assign div_zero = r_div_zero;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider4b.sv
// Testbench for seq_divider4b: directed steps plus a few random divisions.
// Each expected result is queued when start is driven, then popped and
// checked when done is seen.
module tb_seq_divider4b;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  seq_divider4b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           inj_cycle = 0;
  logic [W-1:0] inj_a;
  logic [W-1:0] inj_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`ifdef DIV_ZERO_CHK_EN
    e.dz  = (b == 0);
    e.lat = (b == 0) ? 1 : W + 1;
`else
    e.dz  = 1'b0;
    e.lat = W + 1;
`endif
    sb.push_back(e);
    $display("start %0d / %0d", a, b);
  endtask

  task automatic wait_done(input string tag);
    int   cyc;
    int   busy_cnt;
    exp_t e;
    cyc      = 0;
    busy_cnt = 0;
    do begin
      step();
      cyc++;
      start = 1'b0;
      if (cyc == inj_cycle) begin
        start    = 1'b1;
        dividend = inj_a;
        divisor  = inj_b;
      end
      if (busy === 1'b1 && done !== 1'b1) busy_cnt++;
    end while (done !== 1'b1 && cyc < 30);
    inj_cycle = 0;
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_latency"},   cyc,       e.lat);
    check({tag, "_quotient"},  quotient,  e.q);
    check({tag, "_remainder"}, remainder, e.r);
    check({tag, "_div_zero"},  div_zero,  e.dz);
    check({tag, "_busy_cyc"},  busy_cnt,  e.lat - 1);
    check({tag, "_busy_done"}, busy,      1'b0);
    $display("%s: q=%0d r=%0d dz=%0d lat=%0d busy_cycles=%0d",
             tag, quotient, remainder, div_zero, cyc, busy_cnt);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    drive_start(a, b);
    wait_done(tag);
    step();
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int seen;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();
    check("rst_quotient",  quotient,  0);
    check("rst_remainder", remainder, 0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_div_zero",  div_zero,  0);
    rst = 1'b0;
    step();

    do_op(13, 3, "div13_3");
    do_op(15, 1, "div15_1");
    do_op(7,  9, "div7_9");
    do_op(0,  5, "div0_5");
    do_op(11, 0, "div11_0");
`ifdef DIV_ZERO_CHK_EN
    check("dz_hold", div_zero, 1);
`else
    check("dz_hold", div_zero, 0);
`endif
    do_op(6, 3, "div6_3");

    // A second start two cycles into RUN must not disturb the result.
    inj_cycle = 2;
    inj_a     = 8;
    inj_b     = 2;
    do_op(13, 3, "ignored_start");

    // Back-to-back: new start issued during the done cycle.
    drive_start(13, 3);
    wait_done("b2b_first");
    drive_start(8, 2);
    wait_done("b2b_second");
    step();
    check("b2b_done_pulse", done, 0);

    // Reset mid-RUN discards the operation.
    dividend = 15;
    divisor  = 2;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("midrst_quotient",  quotient,  0);
    check("midrst_remainder", remainder, 0);
    check("midrst_busy",      busy,      0);
    check("midrst_done",      done,      0);
    check("midrst_div_zero",  div_zero,  0);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("midrst_quiet", seen, 0);
    $display("mid-run reset: quiet cycles with activity=%0d", seen);
    do_op(9, 4, "div9_4");

    for (int i = 0; i < 10; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
